// File: rtl/enemy_spawn_sched.sv
// -----------------------------------------------------------------------------
// enemy_spawn_sched
//
// Purpose:
//   Produces the one-cycle `togenerate` request for the enemy slot manager.
//   After each spawn, a gap G = gap_eff + (lfsr[7:0] & GAP_RAND_MASK) is loaded
//   and counted down. When the count expires, a spawn is issued. If the slot
//   table is full, the spawn is held back until a slot frees up, so no request
//   is ever lost. Every LEVEL_STEP spawns the level rises, up to LEVEL_MAX.
//   Each level shortens the minimum gap by GAP_DEC, down to GAP_FLOOR.
//
// Optional feature (compile-time macro SPAWN_BURST_EN):
//   When defined, a LOAD at level >= 4 with lfsr[15] = 1 forces G = 6. This
//   produces a close pair of enemies. When undefined, that check is not built.
//
// Ports:
//   clk3        in   game tick clock
//   reset       in   asynchronous, active-low reset
//   pause       in   1 = freeze every register (togenerate drops to 0)
//   enable      in   1 = game running; 0 = idle and clear game counters
//   slot_full   in   1 = no free slot in the enemy table
//   togenerate  out  registered one-cycle spawn request
//   level       out  current difficulty level
//   spawn_count out  spawns since game start, saturating at 255
//   gap_eff     out  current effective minimum gap (combinational from level)
// -----------------------------------------------------------------------------
module enemy_spawn_sched #(
    parameter logic [15:0] SEED          = 16'h0001,
    parameter int          GAP_MIN       = 24,
    parameter logic [7:0]  GAP_RAND_MASK = 8'h1F,
    parameter int          GAP_DEC       = 2,
    parameter int          GAP_FLOOR     = 12,
    parameter int          LEVEL_STEP    = 8,
    parameter int          LEVEL_MAX     = 7
) (
    input  logic       clk3,
    input  logic       reset,
    input  logic       pause,
    input  logic       enable,
    input  logic       slot_full,
    output logic       togenerate,
    output logic [2:0] level,
    output logic [7:0] spawn_count,
    output logic [7:0] gap_eff
);

    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam int          STEP_W    = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [7:0]          counter_q, counter_d;
    logic [15:0]         lfsr_q, lfsr_d, lfsr_step;
    logic [2:0]          level_q, level_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [7:0]          spawn_q, spawn_d;
    logic                tog_q, tog_d;
    logic [7:0]          load_g;
    logic                spawn_fire;
    int                  gap_int;

    // State register (the datapath registers share the same reset and enable)
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            counter_q <= 8'd0;
            lfsr_q    <= LFSR_INIT;
            level_q   <= 3'd0;
            step_q    <= '0;
            spawn_q   <= 8'd0;
            tog_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            lfsr_q    <= lfsr_d;
            level_q   <= level_d;
            step_q    <= step_d;
            spawn_q   <= spawn_d;
            tog_q     <= tog_d;
        end
    end

    // The minimum gap shrinks with level. The subtraction is signed so that a
    // large level clamps at the floor instead of wrapping.
    always_comb begin
        gap_int = GAP_MIN - int'(level_q) * GAP_DEC;
        if (gap_int < GAP_FLOOR) begin
            gap_int = GAP_FLOOR;
        end
        gap_eff = gap_int[7:0];
    end

    always_comb begin
        load_g = gap_eff + (lfsr_q[7:0] & GAP_RAND_MASK);
`ifdef SPAWN_BURST_EN
        if (level_q >= 3'd4 && lfsr_q[15]) begin
            load_g = 8'd6;
        end
`endif
    end

    // An all-zero LFSR is unreachable from a non-zero seed with these taps.
    // The reload is kept as a guard anyway.
    assign lfsr_step = (lfsr_q == 16'h0000) ? 16'hACE1
                     : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // A spawn fires when the count has expired (COUNT at 0) or a held spawn is
    // pending (HOLD), provided a slot is free. Pause and enable=0 both override it.
    assign spawn_fire = !pause && enable && !slot_full &&
                        ((state_q == S_COUNT && counter_q == 8'd0) || state_q == S_HOLD);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!pause) begin
            if (!enable) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:  state_d = S_LOAD;
                    S_LOAD:  state_d = S_COUNT;
                    S_COUNT: if (counter_q == 8'd0) state_d = slot_full ? S_HOLD : S_LOAD;
                    S_HOLD:  if (!slot_full) state_d = S_LOAD;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Output and datapath logic
    always_comb begin
        counter_d = counter_q;
        lfsr_d    = lfsr_q;
        level_d   = level_q;
        step_d    = step_q;
        spawn_d   = spawn_q;
        tog_d     = 1'b0;
        if (!pause) begin
            lfsr_d = lfsr_step;
            if (!enable) begin
                counter_d = 8'd0;
                level_d   = 3'd0;
                step_d    = '0;
                spawn_d   = 8'd0;
            end else begin
                case (state_q)
                    S_IDLE:  counter_d = 8'd0;
                    S_LOAD:  counter_d = load_g;
                    S_COUNT: if (counter_q != 8'd0) counter_d = counter_q - 8'd1;
                    default: ;
                endcase
                if (spawn_fire) begin
                    tog_d = 1'b1;
                    if (spawn_q != 8'hFF) spawn_d = spawn_q + 8'd1;
                    if (step_q == STEP_W'(LEVEL_STEP - 1)) begin
                        step_d = '0;
                        if (level_q != 3'(LEVEL_MAX)) level_d = level_q + 3'd1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
        end
    end

    assign togenerate  = tog_q;
    assign level       = level_q;
    assign spawn_count = spawn_q;

endmodule
